// File: rtl/mac_opfetch.sv
// mac_opfetch: operand-fetch sequencer for MAC.W/MAC.L @Rm+,@Rn+ using two pipelined AHB-Lite single reads.
// Latency: op_vld 4 cycles after start with zero wait states; every hready-low data cycle adds one.
// Backpressure: operand pair and busy held in ISSUE until op_rdy; start is ignored whenever busy.
module mac_opfetch #(
   parameter int unsigned AW      = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          is_long,
   input  logic          sat,
   input  logic [AW-1:0] addr_m,
   input  logic [AW-1:0] addr_n,
   output logic          busy,
   output logic [AW-1:0] haddr,
   output logic [1:0]    htrans,
   output logic [2:0]    hsize,
   input  logic          hready,
   input  logic          hresp,
   input  logic [31:0]   hrdata,
   output logic          op_vld,
   input  logic          op_rdy,
   output logic [31:0]   op_a,
   output logic [31:0]   op_b,
   output logic          op_long,
   output logic          op_sat,
   output logic [AW-1:0] new_rn,
   output logic [AW-1:0] new_rm,
   output logic          wb,
   output logic          err
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam int         TW            = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_N,
      S_DATA_N,
      S_DATA_M,
      S_ISSUE
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] rn_q, rn_d;
   logic [AW-1:0] rm_q, rm_d;
   logic          long_q, long_d;
   logic          sat_q, sat_d;
   logic          err_q, err_d;
   logic [31:0]   op_a_q, op_a_d;
   logic [31:0]   op_b_q, op_b_d;
   logic [TW-1:0] tcnt_q, tcnt_d;

   logic          misaligned;
   logic          in_bus;
   logic          timeout_hit;
   logic [AW-1:0] inc;

   // Big-endian lane pick: a word at byte offset 0 sits in the upper half of the bus.
   function automatic logic [31:0] lane(input logic [31:0] d, input logic lng, input logic a1);
      logic [15:0] h;
      h = a1 ? d[15:0] : d[31:16];
      return lng ? d : {{16{h[15]}}, h};
   endfunction

   assign misaligned  = is_long ? ((addr_n[1:0] != 2'b00) || (addr_m[1:0] != 2'b00))
                                : (addr_n[0] || addr_m[0]);
   assign in_bus      = (state_q == S_ADDR_N) || (state_q == S_DATA_N) || (state_q == S_DATA_M);
   // Fires on the TIMEOUT-th consecutive stalled cycle, so the abort happens in that same cycle.
   assign timeout_hit = (TIMEOUT != 0) && in_bus && !hready && ((32'(tcnt_q) + 32'd1) == TIMEOUT);

   // Next-state, capture and operand latching for the fetch sequence.
   always_comb begin
      state_d = state_q;
      rn_d    = rn_q;
      rm_d    = rm_q;
      long_d  = long_q;
      sat_d   = sat_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      err_d   = 1'b0;
      tcnt_d  = (in_bus && !hready) ? tcnt_q + TW'(1) : '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               rn_d   = addr_n;
               rm_d   = addr_m;
               long_d = is_long;
               sat_d  = sat;
               if (misaligned) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_ADDR_N;
               end
            end
         end
         S_ADDR_N: begin
            if (timeout_hit) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               tcnt_d  = '0;
            end else if (hready) begin
               state_d = S_DATA_N;
            end
         end
         S_DATA_N: begin
            if (hresp || timeout_hit) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               tcnt_d  = '0;
            end else if (hready) begin
               op_a_d  = lane(hrdata, long_q, rn_q[1]);
               state_d = S_DATA_M;
            end
         end
         S_DATA_M: begin
            if (hresp || timeout_hit) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               tcnt_d  = '0;
            end else if (hready) begin
               op_b_d  = lane(hrdata, long_q, rm_q[1]);
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (op_rdy) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops the bus to IDLE and discards any pending pair.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         rn_q    <= '0;
         rm_q    <= '0;
         long_q  <= 1'b0;
         sat_q   <= 1'b0;
         err_q   <= 1'b0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rn_q    <= rn_d;
         rm_q    <= rm_d;
         long_q  <= long_d;
         sat_q   <= sat_d;
         err_q   <= err_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // Bus and handshake outputs decoded from state; an error response withdraws the pipelined Rm address.
   always_comb begin
      busy   = (state_q != S_IDLE);
      htrans = HTRANS_IDLE;
      haddr  = '0;
      if (state_q == S_ADDR_N) begin
         htrans = HTRANS_NONSEQ;
         haddr  = rn_q;
      end else if (state_q == S_DATA_N) begin
         haddr  = rm_q;
         htrans = hresp ? HTRANS_IDLE : HTRANS_NONSEQ;
      end
      hsize   = long_q ? 3'b010 : 3'b001;
      op_vld  = (state_q == S_ISSUE);
      wb      = op_vld && op_rdy;
      err     = err_q;
      op_a    = op_a_q;
      op_b    = op_b_q;
      op_long = long_q;
      op_sat  = sat_q;
      inc     = long_q ? AW'(4) : AW'(2);
      new_rn  = rn_q + inc;
      new_rm  = rm_q + inc;
   end

endmodule
